// File: rtl/muldiv_seq_pkg.sv
// Shared decode constants, operation and state encodings for the RV32M
// multiply/divide sequencer.
package muldiv_seq_pkg;

  localparam logic [6:0] OPC_REG   = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_e;

  function automatic logic is_mop(input logic [6:0] opcode, input logic [6:0] funct7);
    return (opcode == OPC_REG) && (funct7 == F7_MULDIV);
  endfunction

  function automatic logic is_mul(input muldiv_op_e op);
    return !op[2];
  endfunction

  // MUL is treated as signed; its low word is identical either way.
  function automatic logic rs1_signed(input muldiv_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic rs2_signed(input muldiv_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Execute-stage bus between the pipeline (master) and the mul/div
// sequencer (slave).
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic [31:0]      instruction;
  logic             valid;
  logic             flush;
  logic [WIDTH-1:0] rs1_val;
  logic [WIDTH-1:0] rs2_val;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output instruction, valid, flush, rs1_val, rs2_val,
    input  stall, done, result
  );

  modport slave (
    input  instruction, valid, flush, rs1_val, rs2_val,
    output stall, done, result
  );
endinterface

// File: rtl/muldiv_datapath.sv
// Shared shift-add multiply / restoring divide datapath. Works on operand
// magnitudes; sign correction and word selection happen on the fix strobe.
module muldiv_datapath
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             fix,
  input  logic             early,
  input  muldiv_op_e       op_in,
  input  logic [WIDTH-1:0] rs1_val,
  input  logic [WIDTH-1:0] rs2_val,
  input  logic [WIDTH-1:0] early_val,
  output logic [WIDTH-1:0] result
);

  muldiv_op_e         op;
  logic               neg1, neg2;
  logic [WIDTH-1:0]   acc;   // product high word / partial remainder
  logic [WIDTH-1:0]   mq;    // multiplier / dividend-then-quotient
  logic [WIDTH-1:0]   opb;   // multiplicand / divisor magnitude

  logic               sign1_in, sign2_in;
  logic [WIDTH-1:0]   mag1_in, mag2_in;
  logic [WIDTH:0]     add_a, add_b, add_out, mul_sum;
  logic [WIDTH-1:0]   acc_step, mq_step;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, fix_val;

  assign sign1_in = rs1_signed(op_in) && rs1_val[WIDTH-1];
  assign sign2_in = rs2_signed(op_in) && rs2_val[WIDTH-1];
  assign mag1_in  = sign1_in ? -rs1_val : rs1_val;
  assign mag2_in  = sign2_in ? -rs2_val : rs2_val;

  // One WIDTH+1-bit adder serves both the add step and the trial subtract.
  // Because the remainder stays below the divisor, bit WIDTH of the
  // difference is set exactly when the trial subtract goes negative.
  assign add_a   = is_mul(op) ? {1'b0, acc} : {acc, mq[WIDTH-1]};
  assign add_b   = {1'b0, opb};
  assign add_out = is_mul(op) ? (add_a + add_b) : (add_a - add_b);

  // Next accumulator/shift-register values for one iteration.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    acc_step = acc;
    mq_step  = mq;
    mul_sum  = {1'b0, acc};
    if (is_mul(op)) begin
      if (mq[0]) mul_sum = add_out;
      acc_step = mul_sum[WIDTH:1];
      mq_step  = {mul_sum[0], mq[WIDTH-1:1]};
    end else if (!add_out[WIDTH]) begin
      acc_step = add_out[WIDTH-1:0];
      mq_step  = {mq[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = add_a[WIDTH-1:0];
      mq_step  = {mq[WIDTH-2:0], 1'b0};
    end
  end

  // Sign correction. A zero divisor leaves the dividend magnitude in acc,
  // so only the quotient needs forcing to all ones.
  assign prod     = {acc, mq};
  assign prod_fix = (neg1 ^ neg2) ? -prod : prod;
  assign quo_fix  = (opb == '0) ? '1 : ((neg1 ^ neg2) ? -mq : mq);
  assign rem_fix  = neg1 ? -acc : acc;

  // Low or high word of the product, quotient or remainder.
  always_comb begin
    fix_val = rem_fix;
    case (op)
      OP_MUL:                        fix_val = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_val = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:               fix_val = quo_fix;
      default:                       fix_val = rem_fix;
    endcase
  end

  // Operand latch, iteration registers and the result register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: all datapath registers are reset, not just result, so the block comes up in a fully known state.
    if (rst) begin
      op     <= OP_MUL;
      neg1   <= 1'b0;
      neg2   <= 1'b0;
      acc    <= '0;
      mq     <= '0;
      opb    <= '0;
      result <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (load) begin
        op   <= op_in;
        neg1 <= sign1_in;
        neg2 <= sign2_in;
        acc  <= '0;
        if (is_mul(op_in)) begin
          mq  <= mag2_in;
          opb <= mag1_in;
        end else begin
          mq  <= mag1_in;
          opb <= mag2_in;
        end
      end else if (step) begin
        acc <= acc_step;
        mq  <= mq_step;
      end
      if (fix) begin
        result <= fix_val;
      end else if (early) begin
        result <= early_val;
      end
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// RV32M multiply/divide sequencer: decodes the execute-stage instruction,
// stalls the pipeline while the iterative datapath runs, then pulses done
// with a registered result.
// Optional: define MULDIV_EARLY_OUT_EN to finish divide-by-zero, signed
// overflow and multiply-by-zero in the accept cycle.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  muldiv_seq_if.slave bus
);

  localparam int              CNT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  muldiv_state_e    state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [6:0]       opcode, funct7;
  logic [2:0]       funct3;
  muldiv_op_e       op;
  logic             unused_fields;
  logic             start, early, early_load, step, fix, stall_raw;
  logic [WIDTH-1:0] early_val;

  assign opcode        = bus.instruction[6:0];
  assign funct3        = bus.instruction[14:12];
  assign funct7        = bus.instruction[31:25];
  assign unused_fields = ^{bus.instruction[24:15], bus.instruction[11:7]};
  assign op            = muldiv_op_e'(funct3);

  // flush wins over a coincident start.
  assign start = (state == IDLE) && bus.valid && !bus.flush && is_mop(opcode, funct7);

`ifdef MULDIV_EARLY_OUT_EN
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Special-case results that need no iteration.
  always_comb begin
    early     = 1'b0;
    early_val = '0;
    if (is_mul(op)) begin
      early = (bus.rs1_val == '0) || (bus.rs2_val == '0);
    end else if (bus.rs2_val == '0) begin
      early     = 1'b1;
      early_val = op[1] ? bus.rs1_val : '1;
    end else if ((op == OP_DIV || op == OP_REM) &&
                 bus.rs1_val == MIN_NEG && bus.rs2_val == '1) begin
      early     = 1'b1;
      early_val = op[1] ? '0 : MIN_NEG;
    end
  end
`else
  assign early     = 1'b0;
  assign early_val = '0;
`endif

  assign early_load = start && early;
  assign step       = (state == CALC) && !bus.flush;
  assign fix        = (state == FIX) && !bus.flush;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Iteration counter, cleared on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (start)         cnt <= '0;
    else if (state == CALC) cnt <= cnt + CNT_W'(1);
  end

  // Next-state and stall decode.
  always_comb begin
    next_state = state;
    stall_raw  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          stall_raw  = 1'b1;
          next_state = early ? DONE : CALC;
        end
      end
      CALC: begin
        stall_raw = 1'b1;
        if (bus.flush)              next_state = IDLE;
        else if (cnt == LAST_STEP)  next_state = FIX;
      end
      FIX: begin
        stall_raw  = 1'b1;
        next_state = bus.flush ? IDLE : DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Reset must drop stall at once even with an M-op still presented.
  assign bus.stall = stall_raw && !rst;
  assign bus.done  = (state == DONE);

  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk       (clk),
    .rst       (rst),
    .load      (start),
    .step      (step),
    .fix       (fix),
    .early     (early_load),
    .op_in     (op),
    .rs1_val   (bus.rs1_val),
    .rs2_val   (bus.rs2_val),
    .early_val (early_val),
    .result    (bus.result)
  );

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed cases, randomized operations
// against an arithmetic reference model, flush and mid-operation reset.
module tb_muldiv_seq;

  localparam int W = 32;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011,
                         F_DIV = 3'b100, F_DIVU = 3'b101, F_REM  = 3'b110, F_REMU  = 3'b111;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [31:0] last_result;

  muldiv_seq_if #(.WIDTH(W)) bus ();

  muldiv_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mop(input logic [2:0] f3);
    return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  // Reference: plain 64-bit arithmetic following the RISC-V M rules.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     pv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    pv = '0;
    case (f3)
      F_MUL:    begin pv = sa * sb;           return pv[31:0];  end
      F_MULH:   begin pv = sa * sb;           return pv[63:32]; end
      F_MULHSU: begin pv = sa * longint'(ub); return pv[63:32]; end
      F_MULHU:  begin pv = ua * ub;           return pv[63:32]; end
      F_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        pv = sa / sb;
        return pv[31:0];
      end
      F_DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        pv = ua / ub;
        return pv[31:0];
      end
      F_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        pv = sa % sb;
        return pv[31:0];
      end
      default: begin
        if (b == 0) return a;
        pv = ua % ub;
        return pv[31:0];
      end
    endcase
  endfunction

  // Cycle (accept = 0) in which done is expected.
  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    logic special;
    special = (!f3[2] && (a == 0 || b == 0)) ||
              (f3[2] && b == 0) ||
              ((f3 == F_DIV || f3 == F_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    return (EARLY && special) ? 1 : W + 2;
  endfunction

  task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    bus.instruction = mop(f3);
    bus.valid       = 1'b1;
    bus.rs1_val     = a;
    bus.rs2_val     = b;
  endtask

  // Issue one M-op and check result, done cycle and stall span.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [31:0] exp;
    int          lat;
    int          done_cyc;
    int          stall_cnt;
    exp       = ref_result(f3, a, b);
    lat       = ref_latency(f3, a, b);
    done_cyc  = -1;
    stall_cnt = 0;
    start_op(f3, a, b);
    for (int c = 0; c < 60 && done_cyc < 0; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      @(negedge clk);
      if (bus.done) begin
        done_cyc = c;
        check({tag, "_result"}, bus.result, exp);
        check({tag, "_stall_in_done"}, bus.stall, 0);
        bus.valid = 1'b0;
      end else if (bus.stall) begin
        stall_cnt++;
      end
    end
    bus.valid = 1'b0;
    check({tag, "_done_cycle"}, done_cyc, lat);
    check({tag, "_stall_cycles"}, stall_cnt, lat);
    last_result = exp;
  endtask

  // flush in cycle 10 of a DIV: idle at cycle 11, no done, result kept.
  task automatic flush_test();
    logic [31:0] prev;
    int          dones;
    prev  = last_result;
    dones = 0;
    start_op(F_DIV, 32'hFFFF_FFEC, 32'd6);
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      if (c == 10) bus.flush = 1'b1;
      @(negedge clk);
      if (bus.done) dones++;
    end
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.valid = 1'b0;
    @(negedge clk);
    check("flush_stall_c11", bus.stall, 0);
    check("flush_result_c11", bus.result, prev);
    repeat (40) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("flush_no_done", dones, 0);
    check("flush_result_hold", bus.result, prev);
  endtask

  // Reset in cycle 5 of a MUL, then an ADD must not stall.
  task automatic reset_test();
    int stalls;
    int dones;
    stalls = 0;
    dones  = 0;
    start_op(F_MUL, 32'd123, 32'd456);
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    check("rst_stall", bus.stall, 0);
    check("rst_done", bus.done, 0);
    check("rst_result", bus.result, 0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.valid = 1'b0;
    last_result = '0;
    @(posedge clk);
    #1;
    bus.instruction = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
    bus.valid       = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus.stall) stalls++;
      if (bus.done)  dones++;
    end
    bus.valid = 1'b0;
    check("add_no_stall", stalls, 0);
    check("add_no_done", dones, 0);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    checks          = 0;
    errors          = 0;
    last_result     = '0;
    rst             = 1'b1;
    bus.instruction = '0;
    bus.valid       = 1'b0;
    bus.flush       = 1'b0;
    bus.rs1_val     = '0;
    bus.rs2_val     = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_stall", bus.stall, 0);
    check("reset_done", bus.done, 0);
    check("reset_result", bus.result, 0);

    run_op(F_MUL,   32'd7,          32'hFFFF_FFFD, "mul_7_m3");
    run_op(F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_ones");
    run_op(F_MULH,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh_ones");
    run_op(F_DIV,   32'hFFFF_FFEC, 32'd6,          "div_m20_6");
    run_op(F_REM,   32'hFFFF_FFEC, 32'd6,          "rem_m20_6");
    run_op(F_DIVU,  32'h0000_1234, 32'd0,          "divu_by0");
    run_op(F_REM,   32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    run_op(F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(F_REMU,  32'h8765_4321, 32'd0,          "remu_by0");
    run_op(F_MULHSU, 32'hFFFF_FFFE, 32'hFFFF_FFFF, "mulhsu_m2");

    for (int i = 0; i < 30; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: a = '0;
        1: b = '0;
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = $urandom_range(1, 15);
        default: ;
      endcase
      run_op(f3, a, b, $sformatf("rand%0d_f%0d", i, f3));
    end

    run_op(F_MUL, 32'd7, 32'hFFFF_FFFD, "pre_flush");
    flush_test();
    run_op(F_DIVU, 32'd1000, 32'd7, "post_flush");
    reset_test();
    run_op(F_REMU, 32'd1000, 32'd7, "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative sequencer for the RV32M multiply/divide instructions in the execute stage. It decodes the execute-stage instruction and runs a shared shift-add / restoring-divide datapath for a fixed number of cycles. While it runs, it stalls the pipeline; it then presents a registered 32-bit result for writeback. It sits beside the ALU and its control unit; the ALU ignores M-extension encodings and this block owns them.

## Interface
- `WIDTH`, default 32: operand and result width; the iteration count equals `WIDTH`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `instruction` input 32: instruction in the execute stage.
- `valid` input 1: `instruction` is a live (not bubbled) instruction.
- `flush` input 1: branch taken or kill; aborts any operation in progress.
- `rs1_val` input WIDTH: source operand 1 (multiplicand / dividend).
- `rs2_val` input WIDTH: source operand 2 (multiplier / divisor).
- `stall` output 1: hold the IF/ID/EX pipeline registers.
- `done` output 1: one-cycle pulse; `result` is valid in this cycle.
- `result` output WIDTH: registered result.

## Operation
- An M-op is `opcode`=0110011 and `funct7`=0000001. `funct3` selects the operation:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- Start condition: `state`==IDLE && `valid` && M-op && !`flush`.
- States:
  - IDLE: on start, latch operand magnitudes, sign flags, the op and the select, clear the counter, then go to CALC.
  - CALC: one shift-add (multiply) or one shift-subtract-restore (divide) step per cycle. The counter increments each step; after step `WIDTH`-1, go to FIX.
  - FIX: apply sign correction (negate the product, quotient or remainder per RISC-V rules), select the low or high word, load `result`, then go to DONE.
  - DONE: `done`=1, then go to IDLE.
- Arithmetic: products are formed on 2·WIDTH bits from magnitudes. For MULHSU, only rs1 is signed. For REM and REMU, the remainder sign follows the dividend.
- Divide by zero: quotient = all ones; remainder = rs1.
- Signed overflow (rs1 = 0x8000_0000, rs2 = 0xFFFF_FFFF, DIV/REM): quotient = 0x8000_0000; remainder = 0.
- `flush` in any non-IDLE state returns the FSM to IDLE next cycle. `done` is not asserted and `result` is not updated.
- A non-M-op, or `valid`=0, in IDLE leaves the FSM idle with `stall`=0.

## Timing
- Reset values: `state`=IDLE, `stall`=0, `done`=0, `result`=0, counter=0.
- `stall` is combinational:
  - 1 in IDLE when the start condition holds.
  - 1 throughout CALC and FIX.
  - 0 in DONE, so the pipeline advances in the DONE cycle and the same instruction cannot retrigger.
- Latency, with the accept cycle counted as 0:
  - CALC occupies cycles 1..WIDTH and FIX cycle WIDTH+1.
  - DONE with `done`=1 falls in cycle WIDTH+2, which is 34 for WIDTH=32.
  - `stall` is high for WIDTH+2 cycles.
- `result` holds its value until the next FIX load.
- If `flush` and the start condition coincide in IDLE, `flush` wins: no start.
- Reset asserted mid-operation forces the reset values immediately (asynchronous).
- Back-to-back M-ops: the second is accepted in the IDLE cycle following DONE.

## Configuration
- `MULDIV_EARLY_OUT_EN` defined: in IDLE, divide-by-zero, signed overflow, and multiply with either operand zero skip CALC and FIX.
  - `result` loads the special-case value in the accept cycle; DONE follows in cycle 1.
  - `stall` is high for 1 cycle.
- `MULDIV_EARLY_OUT_EN` undefined: every operation takes the full WIDTH+2 latency. Special-case results are identical either way.

## Structure
- Shared `params.vh` gains:
  - `MULDIV` funct7 constant and the eight funct3 constants (`MUL`..`REMU`), alongside the existing `REG` opcode.
  - The FSM state encodings IDLE, CALC, FIX and DONE (2 bits).
- Sub-module `muldiv_datapath`: accumulator/remainder and quotient/multiplier shift registers, the WIDTH+1-bit adder/subtractor and sign-fix negators. It is driven by step/load/fix strobes from the `muldiv_seq` FSM.

## Test plan
- MUL, rs1=7, rs2=-3 (0xFFFF_FFFD) → `done` in cycle 34, `result`=0xFFFF_FFEB; `stall` high cycles 0..33.
- MULHU, rs1=0xFFFF_FFFF, rs2=0xFFFF_FFFF → `result`=0xFFFF_FFFE; MULH on the same operands → 0x0000_0000.
- DIV, rs1=-20, rs2=6 → `result`=0xFFFF_FFFD; REM on the same operands → 0xFFFF_FFFE.
- DIVU, rs2=0, rs1=0x1234 → `result`=0xFFFF_FFFF; REM with rs1=0x8000_0000 and rs2=-1 → 0. With `MULDIV_EARLY_OUT_EN`, `done` arrives in cycle 1.
- `flush` pulsed in cycle 10 of a DIV → FSM back in IDLE at cycle 11, `stall`=0, no `done`, `result` unchanged.
- `rst` asserted in cycle 5 of a MUL → `stall`, `done` and `result` are 0 immediately. A non-M-op ADD afterwards produces no stall.
